// File: rtl/reg_write_arbiter.sv
// Single register-file write port shared by pipeline writeback and a buffered long-latency unit.
// Optional starvation guard compiled in with REG_WRITE_ARBITER_STARVE_GUARD_EN.
module reg_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard_stall,
  output logic        wb_hold,
  output logic        regWr,
  output logic [4:0]  ws,
  output logic [31:0] wr_data,
  output logic [31:0] busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // The head must be visible in the cycle it is granted, so the buffer is read asynchronously.
  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   busy_reg;
  logic [31:0]   busy_next;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          wb_win;
  logic          fifo_grant;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic          iss_claim;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(DEPTH));
  assign head_rd    = fifo_rd[rd_ptr_reg];
  assign head_data  = fifo_data[rd_ptr_reg];

  assign lu_ready   = !reset && !fifo_full;
  // Results for r0 are accepted and dropped so the unit is never blocked by them.
  assign push       = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign wb_win     = !reset && wb_valid && (wb_rd != 5'd0) && !wb_hold;
  assign fifo_grant = !reset && !wb_win && !fifo_empty;

  assign regWr   = wb_win || fifo_grant;
  assign ws      = wb_win ? wb_rd   : (fifo_grant ? head_rd   : 5'd0);
  assign wr_data = wb_win ? wb_data : (fifo_grant ? head_data : 32'd0);

`ifdef REG_WRITE_ARBITER_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_reg;

  assign wb_hold = !reset && !fifo_empty && (starve_reg == SW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_reg <= '0;
    end else if (!fifo_empty && !fifo_grant) begin
      starve_reg <= starve_reg + 1'b1;
    end else begin
      starve_reg <= '0;
    end
  end
`else
  assign wb_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr_reg]   <= lu_rd;
      fifo_data[wr_ptr_reg] <= lu_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (fifo_grant) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CW'(push) - CW'(fifo_grant);
      busy_reg  <= busy_next;
    end
  end

  // A new claim wins over a retiring write to the same register.
  assign iss_claim    = iss_valid && (iss_rd != 5'd0);
  assign busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    assign busy_next[gi] = (iss_claim && (iss_rd == 5'(gi))) ||
                           (busy_reg[gi] && !(fifo_grant && (head_rd == 5'(gi))));
  end

  assign busy = busy_reg;

  assign hazard_stall = ((rs1 != 5'd0) && busy_reg[rs1]) ||
                        ((rs2 != 5'd0) && busy_reg[rs2]) ||
                        (iss_claim && busy_reg[iss_rd]);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_reg_write_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
`ifdef REG_WRITE_ARBITER_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_rd = '0;
  logic [31:0] lu_data = '0;
  logic        lu_ready;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        hazard_stall;
  logic        wb_hold;
  logic        regWr;
  logic [4:0]  ws;
  logic [31:0] wr_data;
  logic [31:0] busy;

  reg_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .hazard_stall(hazard_stall), .wb_hold(wb_hold),
    .regWr(regWr), .ws(ws), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      model_q[$];
  bit   [31:0] model_busy;
  int          model_starve;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc %0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  // One clock cycle: drive, check the cycle's outputs against the model, then advance the model.
  task automatic step(input bit r, input bit wv, input logic [4:0] wrd, input logic [31:0] wd,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input bit iv, input logic [4:0] ird, input logic [4:0] s1, input logic [4:0] s2);
    bit          e_ready, e_hold, e_wb, e_fifo, e_haz;
    logic [4:0]  e_ws;
    logic [31:0] e_data;
    entry_t      head;
    @(negedge clk);
    reset = r; wb_valid = wv; wb_rd = wrd; wb_data = wd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    iss_valid = iv; iss_rd = ird; rs1 = s1; rs2 = s2;
    #1;
    e_ready = !r && (model_q.size() < DEPTH);
    e_hold  = GUARD && !r && (model_q.size() > 0) && (model_starve >= STARVE_LIMIT);
    e_wb    = !r && wv && (wrd != 0) && !e_hold;
    e_fifo  = !r && !e_wb && (model_q.size() > 0);
    e_ws    = 5'd0;
    e_data  = 32'd0;
    if (e_wb) begin
      e_ws = wrd; e_data = wd;
    end else if (e_fifo) begin
      head = model_q[0]; e_ws = head.rd; e_data = head.data;
    end
    e_haz = (s1 != 0 && model_busy[s1]) || (s2 != 0 && model_busy[s2]) ||
            (iv && ird != 0 && model_busy[ird]);
    check("lu_ready", 32'(lu_ready), 32'(e_ready));
    check("wb_hold", 32'(wb_hold), 32'(e_hold));
    check("regWr", 32'(regWr), 32'(e_wb || e_fifo));
    check("ws", 32'(ws), 32'(e_ws));
    check("wr_data", wr_data, e_data);
    if (!r) begin
      check("busy", busy, model_busy);
      check("hazard_stall", 32'(hazard_stall), 32'(e_haz));
    end
    $display("cyc %0d rst=%0d regWr=%0d ws=%0d data=%h hold=%0d lu_ready=%0d busy=%h",
             cyc, r, regWr, ws, wr_data, wb_hold, lu_ready, busy);
    @(posedge clk);
    cyc++;
    if (r) begin
      model_q.delete();
      model_busy   = '0;
      model_starve = 0;
    end else begin
      if (model_q.size() > 0 && !e_fifo) model_starve++;
      else model_starve = 0;
      if (e_fifo) begin
        head = model_q.pop_front();
        model_busy[head.rd] = 1'b0;
      end
      if (lv && e_ready && lrd != 0) model_q.push_back('{rd: lrd, data: ld});
      if (iv && ird != 0) model_busy[ird] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_busy = '0; model_starve = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5'd4, 32'h1, 1, 5'd4, 32'h2, 1, 5'd4, 0, 0);
    idle(1);

    // Zero-latency writeback pass-through.
    step(0, 1, 5'd5, 32'hAA, 0, 0, 0, 0, 0, 0, 0);

    // Issue rd=7, observe hazard, then the buffered result retires and clears busy.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    step(0, 0, 0, 0, 1, 5'd7, 32'h1234, 0, 0, 5'd7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    idle(1);
    check("busy7_cleared", 32'(busy[7]), 32'd0);

    // Three results back to back while writeback occupies the port.
    step(0, 1, 5'd1, 32'h11, 1, 5'd8, 32'h80, 0, 0, 0, 0);
    step(0, 1, 5'd2, 32'h22, 1, 5'd9, 32'h90, 0, 0, 0, 0);
    step(0, 1, 5'd3, 32'h33, 1, 5'd10, 32'hA0, 0, 0, 0, 0);
    check("full_ready_low", 32'(lu_ready), 32'd0);
    idle(4);

    // Destination 0 requests must be ignored everywhere.
    step(0, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 1, 5'd0, 0, 0);
    idle(1);

    // One buffered entry, then continuous writeback: guard build grants on the 5th denied cycle.
    step(0, 1, 5'd12, 32'h5, 1, 5'd13, 32'h77, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 5'd12, 32'(i), 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Reset with two buffered entries and busy[3] set.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 0);
    step(0, 1, 5'd1, 32'h1, 1, 5'd20, 32'h20, 0, 0, 0, 0);
    step(0, 1, 5'd1, 32'h1, 1, 5'd21, 32'h21, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 0);
    check("post_reset_busy", busy, 32'd0);

    // Random traffic with a bias toward collisions and small register numbers.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wrd, lrd, ird, s1, s2;
      wrd = 5'($urandom_range(0, 15));
      lrd = 5'($urandom_range(0, 15));
      ird = 5'($urandom_range(0, 15));
      s1  = 5'($urandom_range(0, 15));
      s2  = 5'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), wrd, $urandom,
           ($urandom_range(0, 1) == 1), lrd, $urandom,
           ($urandom_range(0, 3) == 0), ird, s1, s2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
